// File: rtl/zap_bp_ctrl_if.sv
// Update/RAM-write bundle for zap_bp_ctrl: branch-state updates flow in, registered
// branch-state RAM writes flow out. The slave modport is the controller's view.
interface zap_bp_ctrl_if #(
    parameter int BP_ENTRIES = 1024
);
    localparam int AW = $clog2(BP_ENTRIES);

    logic          i_upd_valid;
    logic [31:0]   i_upd_pc;
    logic [1:0]    i_upd_state;
    logic          o_ram_wr_en;
    logic [AW-1:0] o_ram_wr_addr;
    logic [1:0]    o_ram_wr_data;

    modport slave (
        input  i_upd_valid, i_upd_pc, i_upd_state,
        output o_ram_wr_en, o_ram_wr_addr, o_ram_wr_data
    );

    modport master (
        output i_upd_valid, i_upd_pc, i_upd_state,
        input  o_ram_wr_en, o_ram_wr_addr, o_ram_wr_data
    );
endinterface

// File: rtl/zap_bp_ctrl.sv
// Branch-predictor state RAM write controller: sweeps every entry to SNT after reset/flush,
// then serialises branch-state updates through a small in-order queue.
// Optional drop statistics counter enabled by defining ZAP_BP_DROP_STATS_EN.
module zap_bp_ctrl #(
    parameter int BP_ENTRIES = 1024,
    parameter int UQ_DEPTH   = 4
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_flush,
    input  logic         i_hold,
    zap_bp_ctrl_if.slave bus,
    output logic         o_busy,
    output logic [15:0]  o_drop_count
);
    localparam int         AW  = $clog2(BP_ENTRIES);
    localparam int         QW  = $clog2(UQ_DEPTH);
    localparam logic [1:0] SNT = 2'b00;

    typedef enum logic {SWEEP, RUN} state_e;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [1:0]    st;
    } upd_t;

    state_e        state, state_nxt;
    logic [AW-1:0] sweep_idx, sweep_idx_nxt;

    upd_t          q_mem [UQ_DEPTH];
    logic [QW-1:0] rd_ptr, wr_ptr;
    logic [QW:0]   q_count;
    logic          q_empty, q_full;
    logic          push, pop, drop, clear;
    upd_t          incoming;

    logic          wr_en_q, wr_en_nxt;
    logic [AW-1:0] wr_addr_q, wr_addr_nxt;
    logic [1:0]    wr_data_q, wr_data_nxt;
    logic          busy_q;

    assign incoming = '{idx: bus.i_upd_pc[AW:1], st: bus.i_upd_state};
    assign q_empty  = (q_count == '0);
    assign q_full   = (q_count == (QW+1)'(UQ_DEPTH));

    // Only the halfword index bits of the PC select an entry.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.i_upd_pc[31:AW+1], bus.i_upd_pc[0]};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= SWEEP;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SWEEP: if (!i_flush && sweep_idx == AW'(BP_ENTRIES - 1)) state_nxt = RUN;
            RUN:   if (i_flush) state_nxt = SWEEP;
        endcase
    end

    // NOTE: every signal gets a default first so no path through this block infers a latch.
    always_comb begin
        push          = 1'b0;
        pop           = 1'b0;
        drop          = 1'b0;
        clear         = 1'b0;
        sweep_idx_nxt = sweep_idx;
        wr_en_nxt     = 1'b0;
        wr_addr_nxt   = wr_addr_q;
        wr_data_nxt   = wr_data_q;

        if (i_flush) begin
            clear         = 1'b1;
            drop          = bus.i_upd_valid;
            sweep_idx_nxt = '0;
        end else if (state == SWEEP) begin
            drop          = bus.i_upd_valid;
            wr_en_nxt     = 1'b1;
            wr_addr_nxt   = sweep_idx;
            wr_data_nxt   = SNT;
            sweep_idx_nxt = sweep_idx + AW'(1);
        end else if (!i_hold) begin
            if (!q_empty) begin
                // Popping frees a slot, so an incoming update always fits behind the head.
                pop         = 1'b1;
                push        = bus.i_upd_valid;
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = q_mem[rd_ptr].idx;
                wr_data_nxt = q_mem[rd_ptr].st;
            end else if (bus.i_upd_valid) begin
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = incoming.idx;
                wr_data_nxt = incoming.st;
            end
        end else if (bus.i_upd_valid) begin
            push = !q_full;
            drop = q_full;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sweep_idx <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            q_count   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= SNT;
            busy_q    <= 1'b1;
        end else begin
            sweep_idx <= sweep_idx_nxt;
            wr_en_q   <= wr_en_nxt;
            wr_addr_q <= wr_addr_nxt;
            wr_data_q <= wr_data_nxt;
            // Busy trails the state by one cycle so it covers exactly the visible sweep writes.
            busy_q    <= (state == SWEEP);
            if (clear) begin
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                q_count <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + QW'(1);
                if (pop)  rd_ptr <= rd_ptr + QW'(1);
                q_count <= q_count + (QW+1)'(push) - (QW+1)'(pop);
            end
        end
    end

    // NOTE: queue storage is not reset; the pointers and count alone decide which slots are valid.
    always_ff @(posedge i_clk) begin
        if (push) q_mem[wr_ptr] <= incoming;
    end

    assign bus.o_ram_wr_en   = wr_en_q;
    assign bus.o_ram_wr_addr = wr_addr_q;
    assign bus.o_ram_wr_data = wr_data_q;
    assign o_busy            = busy_q;

`ifdef ZAP_BP_DROP_STATS_EN
    logic [15:0] drop_cnt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)                     drop_cnt <= '0;
        else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end

    assign o_drop_count = drop_cnt;
`else
    logic unused_drop;
    assign unused_drop  = drop;
    assign o_drop_count = '0;
`endif
endmodule

// File: doc/zap_bp_ctrl.md
ZAP_BP_CTRL -- requirements
Module: zap_bp_ctrl

Interface
REQ-001 SHALL have parameter BP_ENTRIES, default 1024, number of 2-bit branch-state RAM entries (power of two, >=4).
REQ-002 SHALL have parameter UQ_DEPTH, default 4, update-queue depth (power of two, >=2).
REQ-003 SHALL have port i_clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port i_reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_flush  input  1  request to reinitialise every predictor entry.
REQ-006 SHALL have port i_hold  input  1  RAM write port blocked this cycle (pipeline stall).
REQ-007 SHALL have port i_upd_valid  input  1  branch-state update offered this cycle.
REQ-008 SHALL have port i_upd_pc  input  32  branch PC; index = i_upd_pc[$clog2(BP_ENTRIES):1].
REQ-009 SHALL have port i_upd_state  input  2  new 2-bit state (SNT=00, WNT=01, WT=10, ST=11).
REQ-010 SHALL have port o_ram_wr_en  output  1  registered write strobe to branch-state RAM.
REQ-011 SHALL have port o_ram_wr_addr  output  $clog2(BP_ENTRIES)  registered write index.
REQ-012 SHALL have port o_ram_wr_data  output  2  registered write state.
REQ-013 SHALL have port o_busy  output  1  high while sweeping; fetch then forces predictions to SNT.
REQ-014 SHALL have port o_drop_count  output  16  dropped-update counter (see Configuration).

Function
REQ-015 SHALL implement FSM states SWEEP and RUN; sweep index register width $clog2(BP_ENTRIES).
REQ-016 In SWEEP, each cycle SHALL register o_ram_wr_en=1, addr=index, data=SNT, index+1, ignoring i_hold.
REQ-017 SWEEP SHALL exit to RUN after the write of index BP_ENTRIES-1; index wraps to 0; sweep lasts exactly BP_ENTRIES cycles.
REQ-018 o_busy SHALL be 1 in SWEEP and 0 in RUN, registered with the state.
REQ-019 i_flush in RUN SHALL enter SWEEP next cycle at index 0 and discard all queued updates.
REQ-020 i_flush during SWEEP SHALL restart sweep at index 0.
REQ-021 i_upd_valid during SWEEP or coincident with i_flush SHALL be dropped.
REQ-022 In RUN, updates SHALL be written in arrival order through a UQ_DEPTH-entry FIFO of {index,state}.
REQ-023 In RUN with i_hold=0: queue non-empty -> pop head onto write outputs next cycle; queue empty and i_upd_valid -> bypass, write outputs next cycle (latency 1).
REQ-024 In RUN with i_hold=1: o_ram_wr_en SHALL be 0 next cycle; incoming update pushed if space.
REQ-025 Full queue with simultaneous pop SHALL accept the incoming update; full without pop SHALL drop the incoming update, queue unchanged.
REQ-026 o_ram_wr_en SHALL be 0 in any RUN cycle with no pop and no bypass; addr/data then hold last values.
REQ-027 At most one RAM write per cycle; no two writes reordered.

Reset
REQ-028 i_reset_n low SHALL immediately force: state=SWEEP, index=0, queue empty, o_ram_wr_en=0, o_ram_wr_addr=0, o_ram_wr_data=SNT, o_busy=1, o_drop_count=0.
REQ-029 First sweep write SHALL appear on the first rising edge after i_reset_n deasserts; reset mid-sweep or with a full queue discards all progress.

Configuration
REQ-030 Macro ZAP_BP_DROP_STATS_EN defined: o_drop_count SHALL increment by 1 per dropped update (REQ-021, REQ-025), saturating at 16'hFFFF, cleared only by reset.
REQ-031 Macro ZAP_BP_DROP_STATS_EN undefined: o_drop_count SHALL be constant 0 and no counter flops exist; all other behaviour identical.

Verification (bench BP_ENTRIES=16, UQ_DEPTH=4, stats enabled)
REQ-032 Release reset -> 16 consecutive writes addr 0..15 data 00, o_busy=1 throughout, o_busy=0 on cycle 17.
REQ-033 RUN, i_hold=0, upd pc=32'h0000_0008 state 11 at cycle t -> cycle t+1 wr_en=1 addr=4 data=11.
REQ-034 i_hold=1 for 6 cycles, updates pc 2,4,6,8,10 -> first four queued, fifth dropped, drop_count=1; hold released -> four writes addr 1,2,3,4 in order, one per cycle.
REQ-035 Queue holds 3 entries, i_flush pulsed -> next 16 cycles sweep from addr 0, queued entries never written, update during sweep raises drop_count by 1.
REQ-036 i_flush pulsed at sweep index 9 -> next write addr 0, sweep completes 16 cycles later.
REQ-037 i_reset_n asserted mid-cycle with queue full -> outputs reach reset values before next clock edge; drop_count=0.
